// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared constants, maximal-length tap table and seed rotate helper for lfsr_bank
package lfsr_pkg;

    localparam int          LFSR_DEFAULT_WIDTH    = 17;
    localparam int          LFSR_DEFAULT_CHANNELS = 4;
    localparam logic [31:0] LFSR_DEFAULT_TAPS     = 32'h0001_2000;
    localparam logic [31:0] LFSR_DEFAULT_SEED     = 32'h0000_002B;

    // Bit i set means state[i] feeds the XOR; shift direction is toward the MSB.
    function automatic logic [31:0] lfsr_max_taps(input int unsigned width);
        case (width)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Rotate the low 'width' bits of seed left by rot; a nonzero seed stays nonzero.
    function automatic logic [31:0] lfsr_seed_rotl(input logic [31:0] seed,
                                                   input int unsigned rot,
                                                   input int unsigned width);
        logic [31:0] r;
        int unsigned k;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                k = (i + rot) % width;
                r[k[4:0]] = seed[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - one Fibonacci LFSR channel with load, lock-up protection and wrap detect
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = LFSR_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_DEFAULT_TAPS),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_DEFAULT_SEED)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_adv,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    output logic [WIDTH-1:0] o_state,
    output logic             o_wrap
);

    logic [WIDTH-1:0] r_state;
    logic             r_wrap;
    logic             w_fb;
    logic [WIDTH-1:0] w_next;

    assign w_fb   = ^(r_state & TAPS);
    assign w_next = {r_state[WIDTH-2:0], w_fb};

    // Load wins over advance; zero data would lock the register, so it restores the seed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SEED;
            r_wrap  <= 1'b0;
        end else if (i_load) begin
            r_state <= (i_load_data == '0) ? SEED : i_load_data;
            r_wrap  <= 1'b0;
        end else if (i_adv) begin
            r_state <= w_next;
            r_wrap  <= (w_next == SEED);
        end else begin
            r_wrap  <= 1'b0;
        end
    end

    assign o_state = r_state;
    assign o_wrap  = r_wrap;

endmodule

// File: rtl/lfsr_bank.sv
// rtl/lfsr_bank.sv - bank of independent LFSR channels with a round-robin valid/ready read port
module lfsr_bank
    import lfsr_pkg::*;
#(
    parameter int               WIDTH    = LFSR_DEFAULT_WIDTH,
    parameter int               CHANNELS = LFSR_DEFAULT_CHANNELS,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(LFSR_DEFAULT_TAPS),
    parameter logic [WIDTH-1:0] SEED     = WIDTH'(LFSR_DEFAULT_SEED),
    localparam int              CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       step_en,
    input  logic                      load_en,
    input  logic [CH_W-1:0]           load_ch,
    input  logic [WIDTH-1:0]          load_data,
    output logic [CHANNELS*WIDTH-1:0] state_out,
    output logic [CHANNELS-1:0]       wrap_tick,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [WIDTH-1:0]          rd_data,
    output logic [CH_W-1:0]           rd_ch
);

    logic [WIDTH-1:0]    w_states [CHANNELS];
    logic [CHANNELS-1:0] w_adv;
    logic [CHANNELS-1:0] w_load;
    logic                w_hs;
    logic [CH_W-1:0]     w_rd_ch_next;
    logic                r_rd_valid;
    logic [CH_W-1:0]     r_rd_ch;

    assign w_hs = r_rd_valid & rd_ready;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        localparam logic [WIDTH-1:0] SEED_C = WIDTH'(lfsr_seed_rotl(32'(SEED), c, WIDTH));

        // A step request and a read of the same channel merge into a single advance.
        assign w_adv[c]  = step_en[c] | (w_hs & (r_rd_ch == CH_W'(c)));
        assign w_load[c] = load_en & (load_ch == CH_W'(c));

        lfsr_core #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS),
            .SEED  (SEED_C)
        ) u_core (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_adv       (w_adv[c]),
            .i_load      (w_load[c]),
            .i_load_data (load_data),
            .o_state     (w_states[c]),
            .o_wrap      (wrap_tick[c])
        );

        assign state_out[c*WIDTH +: WIDTH] = w_states[c];
    end

    always_comb begin
        rd_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (r_rd_ch == CH_W'(c)) begin
                rd_data = w_states[c];
            end
        end
    end

    assign w_rd_ch_next = (r_rd_ch == CH_W'(CHANNELS - 1)) ? '0 : r_rd_ch + CH_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_ch    <= '0;
        end else begin
            r_rd_valid <= 1'b1;
            if (w_hs) begin
                r_rd_ch <= w_rd_ch_next;
            end
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_ch    = r_rd_ch;

endmodule

// File: tb/tb_lfsr_bank.sv
// tb/tb_lfsr_bank.sv - self-checking bench for lfsr_bank (default bank plus a 4-bit single-channel instance)
module tb_lfsr_bank;

    localparam int          W      = 17;
    localparam int          N      = 4;
    localparam logic [16:0] TAPS_D = 17'h12000;
    localparam logic [16:0] SEED_D = 17'h0002B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [N-1:0]  step_en;
    logic          load_en;
    logic [1:0]    load_ch;
    logic [W-1:0]  load_data;
    logic [N*W-1:0] state_out;
    logic [N-1:0]  wrap_tick;
    logic          rd_valid;
    logic          rd_ready;
    logic [W-1:0]  rd_data;
    logic [1:0]    rd_ch;

    logic          s_rst_n;
    logic [0:0]    s_step;
    logic          s_load_en;
    logic [0:0]    s_load_ch;
    logic [3:0]    s_load_data;
    logic [3:0]    s_state_out;
    logic [0:0]    s_wrap;
    logic          s_rd_valid;
    logic          s_rd_ready;
    logic [3:0]    s_rd_data;
    logic [0:0]    s_rd_ch;

    lfsr_bank u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_en   (step_en),
        .load_en   (load_en),
        .load_ch   (load_ch),
        .load_data (load_data),
        .state_out (state_out),
        .wrap_tick (wrap_tick),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_ch     (rd_ch)
    );

    lfsr_bank #(
        .WIDTH    (4),
        .CHANNELS (1),
        .TAPS     (4'hC),
        .SEED     (4'h1)
    ) u_small (
        .clk       (clk),
        .rst_n     (s_rst_n),
        .step_en   (s_step),
        .load_en   (s_load_en),
        .load_ch   (s_load_ch),
        .load_data (s_load_data),
        .state_out (s_state_out),
        .wrap_tick (s_wrap),
        .rd_valid  (s_rd_valid),
        .rd_ready  (s_rd_ready),
        .rd_data   (s_rd_data),
        .rd_ch     (s_rd_ch)
    );

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state: plain integers, arithmetic advance.
    int unsigned m_st [N];
    logic [N-1:0] m_wrap;
    int           m_ch;
    logic         m_valid;

    function automatic int unsigned seed_of(int c);
        logic [33:0] d;
        d = {SEED_D, SEED_D} >> (17 - c);
        return int'(d[16:0]);
    endfunction

    function automatic int unsigned adv(int unsigned s, int unsigned taps, int w);
        int unsigned fb;
        fb = $countones(s & taps) % 2;
        return ((s << 1) | fb) & ((32'd1 << w) - 1);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        logic hs;
        hs = m_valid && rd_ready;
        if (!rst_n) begin
            for (int c = 0; c < N; c++) m_st[c] = seed_of(c);
            m_wrap  = '0;
            m_ch    = 0;
            m_valid = 1'b0;
        end else begin
            for (int c = 0; c < N; c++) begin
                m_wrap[c] = 1'b0;
                if (load_en && int'(load_ch) == c) begin
                    m_st[c] = (load_data == '0) ? seed_of(c) : int'(load_data);
                end else if (step_en[c] || (hs && m_ch == c)) begin
                    m_st[c]   = adv(m_st[c], int'(TAPS_D), W);
                    m_wrap[c] = (m_st[c] == seed_of(c));
                end
            end
            if (hs) m_ch = (m_ch + 1) % N;
            m_valid = 1'b1;
        end
    endtask

    task automatic compare_model(input string tag);
        logic [N*W-1:0] e;
        for (int c = 0; c < N; c++) e[c*W +: W] = 17'(m_st[c]);
        check({tag, " state_out"}, 128'(state_out), 128'(e));
        check({tag, " wrap_tick"}, 128'(wrap_tick), 128'(m_wrap));
        check({tag, " rd_valid"},  128'(rd_valid),  128'(m_valid));
        check({tag, " rd_ch"},     128'(rd_ch),     128'(m_ch));
        check({tag, " rd_data"},   128'(rd_data),   128'(m_st[m_ch]));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_model(tag);
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  step;
        logic        ld;
        logic [1:0]  lch;
        logic [16:0] ldat;
        logic        rdy;
        int          chk_ch;
        logic [16:0] exp_val;
        logic [1:0]  exp_rd_ch;
        logic        exp_valid;
    } vec_t;

    vec_t tbl [12];
    logic [1:0] exp_rr [4];

    initial begin
        int unsigned ms;
        int unsigned prev_wrap;
        int          wraps;
        int          distinct;
        int          last_gap;
        logic [15:0] seen;

        tbl[0]  = '{1'b0, 4'h0, 1'b0, 2'd0, 17'h0,     1'b0, 0, 17'h0002B, 2'd0, 1'b0};
        tbl[1]  = '{1'b1, 4'h0, 1'b0, 2'd0, 17'h0,     1'b0, 3, 17'h00158, 2'd0, 1'b1};
        tbl[2]  = '{1'b1, 4'h1, 1'b0, 2'd0, 17'h0,     1'b0, 0, 17'h00056, 2'd0, 1'b1};
        tbl[3]  = '{1'b1, 4'h0, 1'b0, 2'd0, 17'h0,     1'b0, 1, 17'h00056, 2'd0, 1'b1};
        tbl[4]  = '{1'b1, 4'h0, 1'b1, 2'd2, 17'h0,     1'b0, 2, 17'h000AC, 2'd0, 1'b1};
        tbl[5]  = '{1'b1, 4'h4, 1'b1, 2'd2, 17'h1FFFF, 1'b0, 2, 17'h1FFFF, 2'd0, 1'b1};
        tbl[6]  = '{1'b1, 4'h4, 1'b0, 2'd0, 17'h0,     1'b0, 2, 17'h1FFFE, 2'd0, 1'b1};
        tbl[7]  = '{1'b1, 4'h0, 1'b0, 2'd0, 17'h0,     1'b1, 0, 17'h000AC, 2'd1, 1'b1};
        tbl[8]  = '{1'b1, 4'hF, 1'b0, 2'd0, 17'h0,     1'b1, 1, 17'h000AC, 2'd2, 1'b1};
        tbl[9]  = '{1'b1, 4'h0, 1'b1, 2'd2, 17'h5,     1'b1, 2, 17'h00005, 2'd3, 1'b1};
        tbl[10] = '{1'b1, 4'hF, 1'b0, 2'd0, 17'h0,     1'b1, 3, 17'h00560, 2'd0, 1'b1};
        tbl[11] = '{1'b0, 4'hF, 1'b1, 2'd1, 17'h1234,  1'b1, 1, 17'h00056, 2'd0, 1'b0};
        exp_rr[0] = 2'd1; exp_rr[1] = 2'd2; exp_rr[2] = 2'd3; exp_rr[3] = 2'd0;

        rst_n = 1'b0; step_en = '0; load_en = 1'b0; load_ch = '0; load_data = '0; rd_ready = 1'b0;
        s_rst_n = 1'b0; s_step = '0; s_load_en = 1'b0; s_load_ch = '0; s_load_data = '0; s_rd_ready = 1'b0;
        m_valid = 1'b0; m_ch = 0; m_wrap = '0;
        for (int c = 0; c < N; c++) m_st[c] = 0;

        for (int i = 0; i < 12; i++) begin
            rst_n = tbl[i].rst; step_en = tbl[i].step; load_en = tbl[i].ld;
            load_ch = tbl[i].lch; load_data = tbl[i].ldat; rd_ready = tbl[i].rdy;
            cycle($sformatf("vec%0d", i));
            check($sformatf("vec%0d chan", i), 128'(state_out[tbl[i].chk_ch*W +: W]), 128'(tbl[i].exp_val));
            check($sformatf("vec%0d rd_ch", i), 128'(rd_ch), 128'(tbl[i].exp_rd_ch));
            check($sformatf("vec%0d rd_valid", i), 128'(rd_valid), 128'(tbl[i].exp_valid));
        end

        rst_n = 1'b1; step_en = '0; load_en = 1'b0; rd_ready = 1'b0;
        cycle("release");
        rd_ready = 1'b1; step_en = 4'hF;
        for (int k = 0; k < 4; k++) begin
            cycle($sformatf("rr%0d", k));
            check($sformatf("rr%0d rd_ch", k), 128'(rd_ch), 128'(exp_rr[k]));
        end

        rd_ready = 1'b0; step_en = '0; load_en = 1'b1; load_ch = 2'd0; load_data = 17'h10015;
        cycle("preload");
        load_en = 1'b0; step_en = 4'h1;
        cycle("wrap_step");
        check("wrap pulse", 128'(wrap_tick), 128'(4'b0001));
        step_en = '0;
        cycle("wrap_idle");
        check("wrap clear", 128'(wrap_tick), 128'(4'b0000));

        for (int k = 0; k < 400; k++) begin
            rst_n     = ($urandom_range(0, 60) != 0);
            step_en   = 4'($urandom_range(0, 15));
            load_en   = ($urandom_range(0, 7) == 0);
            load_ch   = 2'($urandom_range(0, 3));
            load_data = ($urandom_range(0, 3) == 0) ? 17'h0 : 17'($urandom);
            rd_ready  = 1'($urandom_range(0, 1));
            cycle($sformatf("rand%0d", k));
        end

        rst_n = 1'b0; step_en = '0; load_en = 1'b0; rd_ready = 1'b0;
        @(posedge clk); #1;
        check("small reset state", 128'(s_state_out), 128'(4'h1));
        check("small reset valid", 128'(s_rd_valid), 128'(1'b0));
        s_rst_n = 1'b1; s_step = 1'b1; s_load_en = 1'b1; s_load_ch = 1'b1; s_load_data = 4'h3; s_rd_ready = 1'b1;
        ms = 1; seen = '0; wraps = 0; distinct = 0; prev_wrap = 0; last_gap = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            ms = adv(ms, 32'hC, 4);
            check($sformatf("small state%0d", k), 128'(s_state_out), 128'(ms));
            check($sformatf("small wrap%0d", k), 128'(s_wrap), 128'(ms == 1));
            if (k <= 15 && s_state_out != 4'h0 && !seen[s_state_out]) begin
                seen[s_state_out] = 1'b1;
                distinct++;
            end
            if (s_wrap == 1'b1) begin
                wraps++;
                last_gap = k - int'(prev_wrap);
                prev_wrap = k;
            end
        end
        check("small distinct", 128'(distinct), 128'(15));
        check("small wraps", 128'(wraps), 128'(2));
        check("small wrap gap", 128'(last_gap), 128'(15));
        check("small rd_ch", 128'(s_rd_ch), 128'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
